// File: rtl/conc_stim_pkg.sv
// Shared types for the concolic stimulus sequencer: FSM states, opcode and
// capture-record layouts at the default geometry.
package conc_stim_pkg;

  localparam int CS_DATA_W    = 8;
  localparam int CS_DEPTH     = 16;
  localparam int CS_ADDR_W    = $clog2(CS_DEPTH);
  localparam int CS_CAP_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic                 obs;
    logic [CS_DATA_W-1:0] vec;
  } opcode_t;

  typedef struct packed {
    logic [CS_DATA_W-1:0] data;
    logic [CS_ADDR_W-1:0] step;
  } cap_rec_t;

endpackage

// File: rtl/conc_cap_fifo.sv
// First-word-fall-through FIFO for capture records; a push on a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module conc_cap_fifo
  import conc_stim_pkg::*;
#(
  parameter type T     = cap_rec_t,
  parameter int  DEPTH = CS_CAP_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  output logic full,
  input  logic pop,
  output T     pop_data,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [PW:0] wr_q, wr_d, rd_q, rd_d;
  logic        do_push, do_pop;

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_q[PW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[PW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

endmodule

// File: rtl/conc_stim_sequencer.sv
// Replays a loadable opcode table into the DUT one vector per clock and
// queues DUT outputs on observed steps. Record widths follow the package.
module conc_stim_sequencer
  import conc_stim_pkg::*;
#(
  parameter int DATA_W    = CS_DATA_W,
  parameter int DEPTH     = CS_DEPTH,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int CAP_DEPTH = CS_CAP_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W:0]   cfg_wdata,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] dut_in,
  output logic              dut_obs,
  input  logic [DATA_W-1:0] dut_out,
  output logic              cap_valid,
  input  logic              cap_ready,
  output logic [DATA_W-1:0] cap_data,
  output logic [ADDR_W-1:0] cap_step,
  output logic              overflow
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

  logic [DATA_W:0]   tbl [DEPTH];
  opcode_t           op;
  state_e            state_q, state_d;
  logic [ADDR_W:0]   pc_q, pc_d, len_q, len_d;
  logic [DATA_W-1:0] in_q, in_d;
  logic              obs_q, obs_d, ovf_q, ovf_d;
  logic [ADDR_W-1:0] step_q, step_d;
  logic              start_acc;

  cap_rec_t push_rec, head;
  logic     push, pop, full, empty, drop;

  // Table is write-protected for the whole playback, including DONE.
  always_ff @(posedge clk) begin
    if (cfg_we && !busy) tbl[cfg_addr] <= cfg_wdata;
  end

  assign op        = tbl[pc_q[ADDR_W-1:0]];
  assign start_acc = (state_q == IDLE) && start && !abort;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    in_d    = in_q;
    obs_d   = obs_q;
    step_d  = step_q;
    unique case (state_q)
      IDLE: begin
        if (start_acc) begin
          pc_d    = '0;
          len_d   = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
          state_d = (cfg_len == '0) ? DONE : RUN;
        end
      end
      RUN, HOLD: begin
        // Every edge sampled with pause high stalls exactly one step.
        if (pause) begin
          state_d = HOLD;
          obs_d   = 1'b0;
        end else begin
          in_d    = op.vec;
          obs_d   = op.obs;
          step_d  = pc_q[ADDR_W-1:0];
          pc_d    = pc_q + 1'b1;
          state_d = (pc_q == len_q - 1'b1) ? DONE : RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
        obs_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      pc_d    = '0;
      in_d    = '0;
      obs_d   = 1'b0;
    end
  end

  assign push          = obs_q && (state_q != HOLD);
  assign push_rec.data = dut_out;
  assign push_rec.step = step_q;
  assign pop           = cap_valid && cap_ready;
  assign drop          = push && full && !pop;
  assign ovf_d         = start_acc ? 1'b0 : (ovf_q || drop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      in_q    <= '0;
      obs_q   <= 1'b0;
      step_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      in_q    <= in_d;
      obs_q   <= obs_d;
      step_q  <= step_d;
      ovf_q   <= ovf_d;
    end
  end

  conc_cap_fifo #(.T(cap_rec_t), .DEPTH(CAP_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_rec),
    .full      (full),
    .pop       (pop),
    .pop_data  (head),
    .empty     (empty)
  );

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE) && !abort;
  assign dut_in    = in_q;
  assign dut_obs   = obs_q;
  assign cap_valid = !empty;
  assign cap_data  = head.data;
  assign cap_step  = head.step;
  assign overflow  = ovf_q;

endmodule
